mem_stage: RTL and testbench

- Memory-access/writeback stage downstream of the ALU controller.
- Consumes the controller's `store`/`load` strobes, effective address, store data and register-writeback request.
- Performs the data-memory transaction over a req/ack bus: lane alignment, byte enables, load sign/zero extension.
- Drives the register-file write port and a `busy` stall back to the fetch/decode side.

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory request/acknowledge bus between the memory
// stage (master) and the data memory (slave).
//
//   req    master->slave  request pending, held until ack
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  lane-replicated write data
//   be     master->slave  byte enables, one per lane
//   ack    slave->master  request completes this cycle
//   rdata  slave->master  read word, valid with ack
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- memory-access / writeback stage.
//
// Accepts one instruction when valid && !busy, performs the data-memory
// access over the dmem req/ack bus (lane alignment, byte enables, load
// extension) and drives the register-file write port.
//
// Ports:
//   CLK, RST_X        clock, asynchronous active-low reset
//   valid             instruction present on the inputs
//   store, load       access type strobes
//   funct3            access size / signedness
//   addr              effective byte address
//   wd_mem            store data, right-justified
//   we_reg, wd_reg    writeback request and data for non-load instructions
//   rd_in             destination register
//   busy              stage occupied, upstream must hold
//   dmem              data-memory bus (master side)
//   wb_en/wb_rd/wb_data  register-file write port, one-cycle strobe
//   misalign          one-cycle pulse: misaligned or illegal access
//   timeout           one-cycle pulse: memory did not answer in time
//
// Build option: define MEM_TIMEOUT_EN to enable the access watchdog
// (TIMEOUT_CYC request cycles). Without it the stage waits indefinitely
// and timeout is tied low.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | ready; non-memory ops and faults complete from here
// S_ACCESS | dmem.req high, waiting for dmem.ack
// S_WB     | load data registered, wb_en strobing this cycle
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        valid,
  input  logic        store,
  input  logic        load,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wd_mem,
  input  logic        we_reg,
  input  logic [31:0] wd_reg,
  input  logic [4:0]  rd_in,
  output logic        busy,
  mem_stage_if.master dmem,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_ofs_q, ld_ofs_d;
  logic [4:0]  ld_rd_q, ld_rd_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  // The watchdog length has no meaning without the watchdog.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // Decode of the instruction currently on the inputs.
  logic        is_byte, is_half, is_word;
  logic        f3_ld_ok, f3_st_ok, aligned, mem_ok;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  always_comb begin
    is_byte  = (funct3[1:0] == 2'b00);
    is_half  = (funct3[1:0] == 2'b01);
    is_word  = (funct3[1:0] == 2'b10);
    f3_ld_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    f3_st_ok = !funct3[2] && (funct3[1:0] != 2'b11);
    aligned  = is_byte || (is_half && !addr[0]) || (is_word && (addr[1:0] == 2'b00));
    // load && store together falls out of both terms and faults.
    mem_ok   = ((load && !store && f3_ld_ok) || (store && !load && f3_st_ok)) && aligned;

    if (is_word)      be_new = 4'b1111;
    else if (is_half) be_new = 4'b0011 << addr[1:0];
    else              be_new = 4'b0001 << addr[1:0];

    if (is_byte)      wdata_new = {4{wd_mem[7:0]}};
    else if (is_half) wdata_new = {2{wd_mem[15:0]}};
    else              wdata_new = wd_mem;
  end

  // Load extraction from the acknowledged read word.
  logic [31:0] rd_lane;
  logic [31:0] ld_ext;

  always_comb begin
    rd_lane = dmem.rdata >> {ld_ofs_q, 3'b000};
    case (ld_f3_q)
      3'b000:  ld_ext = {{24{rd_lane[7]}}, rd_lane[7:0]};
      3'b001:  ld_ext = {{16{rd_lane[15]}}, rd_lane[15:0]};
      3'b100:  ld_ext = {24'd0, rd_lane[7:0]};
      3'b101:  ld_ext = {16'd0, rd_lane[15:0]};
      default: ld_ext = dmem.rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_en_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    ld_f3_d    = ld_f3_q;
    ld_ofs_d   = ld_ofs_q;
    ld_rd_d    = ld_rd_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (mem_ok) begin
            state_d  = S_ACCESS;
            req_d    = 1'b1;
            we_d     = store;
            addr_d   = {addr[31:2], 2'b00};
            wdata_d  = wdata_new;
            be_d     = be_new;
            ld_f3_d  = funct3;
            ld_ofs_d = addr[1:0];
            ld_rd_d  = rd_in;
`ifdef MEM_TIMEOUT_EN
            // Down-counter reaches zero in the last allowed request cycle.
            cnt_d    = CNT_W'(TIMEOUT_CYC - 1);
`endif
          end else if (load || store) begin
            misalign_d = 1'b1;
          end else begin
            wb_en_d   = we_reg && (rd_in != 5'd0);
            wb_rd_d   = rd_in;
            wb_data_d = wd_reg;
          end
        end
      end

      S_ACCESS: begin
        // Ack is checked ahead of expiry so a last-cycle ack completes normally.
        if (dmem.ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_WB;
            wb_en_d   = (ld_rd_q != 5'd0);
            wb_rd_d   = ld_rd_q;
            wb_data_d = ld_ext;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == '0) begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      ld_f3_q    <= '0;
      ld_ofs_q   <= '0;
      ld_rd_q    <= '0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      ld_f3_q    <= ld_f3_d;
      ld_ofs_q   <= ld_ofs_d;
      ld_rd_q    <= ld_rd_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy       = (state_q != S_IDLE);
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage.
// Inputs are driven and outputs sampled at the falling clock edge. Expected
// values come from an arithmetic model of the access rules (size in bytes,
// lane shifts, masks) evaluated per instruction.
module tb_mem_stage;
  localparam int unsigned TOC = 4;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        valid = 1'b0;
  logic        store = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wd_mem = '0;
  logic        we_reg = 1'b0;
  logic [31:0] wd_reg = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        timeout;

  int n_pass = 0;
  int n_fail = 0;

  logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always #5 CLK = ~CLK;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT_CYC(TOC)) dut (
    .CLK      (CLK),
    .RST_X    (RST_X),
    .valid    (valid),
    .store    (store),
    .load     (load),
    .funct3   (funct3),
    .addr     (addr),
    .wd_mem   (wd_mem),
    .we_reg   (we_reg),
    .wd_reg   (wd_reg),
    .rd_in    (rd_in),
    .busy     (busy),
    .dmem     (dmem),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .misalign (misalign),
    .timeout  (timeout)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    valid  = 1'b0;
    load   = 1'($urandom);
    store  = 1'($urandom);
    funct3 = 3'($urandom);
    addr   = $urandom;
    wd_mem = $urandom;
    we_reg = 1'($urandom);
    wd_reg = $urandom;
    rd_in  = 5'($urandom);
  endtask

  // Presents one instruction at the current falling edge and checks it to completion.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wdm, input bit wer, input logic [31:0] wdr,
                       input logic [4:0] rd, input int waits, input logic [31:0] rdat);
    int          size;
    bit          legal, fault, sgn;
    logic [3:0]  ebe;
    logic [31:0] ewd, ev, mask;

    size = 1 << (f3 % 4);
    sgn  = (f3 < 3'd4);
    if (ld && !st)      legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else if (st && !ld) legal = (f3 <= 3'd2);
    else                legal = 1'b0;
    fault = (ld || st) && (!legal || (a % size) != 0);
    ebe   = 4'(((1 << size) - 1) << (a % 4));
    for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wdm[8*(l % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
    ev   = (rdat >> (8 * (a % 4))) & mask;
    if (sgn && size < 4 && ev[8*size-1]) ev = ev | ~mask;

    check("idle_before", 32'(busy), 32'd0);
    valid = 1'b1; load = ld; store = st; funct3 = f3; addr = a;
    wd_mem = wdm; we_reg = wer; wd_reg = wdr; rd_in = rd;
    @(negedge CLK);
    scramble();

    if (!(ld || st)) begin
      check("nm_wb_en", 32'(wb_en), 32'(wer && rd != 0));
      if (wer && rd != 0) begin
        check("nm_wb_rd", 32'(wb_rd), 32'(rd));
        check("nm_wb_data", wb_data, wdr);
      end
      check("nm_req", 32'(dmem.req), 32'd0);
      check("nm_misalign", 32'(misalign), 32'd0);
    end else if (fault) begin
      check("fa_misalign", 32'(misalign), 32'd1);
      check("fa_req", 32'(dmem.req), 32'd0);
      check("fa_busy", 32'(busy), 32'd0);
      check("fa_wb_en", 32'(wb_en), 32'd0);
      @(negedge CLK);
      check("fa_pulse_end", 32'(misalign), 32'd0);
      check("fa_req_later", 32'(dmem.req), 32'd0);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        check("acc_req", 32'(dmem.req), 32'd1);
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_we", 32'(dmem.we), 32'(st));
        check("acc_addr", dmem.addr, a & 32'hFFFF_FFFC);
        check("acc_be", 32'(dmem.be), 32'(ebe));
        if (st) check("acc_wdata", dmem.wdata, ewd);
        check("acc_wb_en", 32'(wb_en), 32'd0);
        dmem.ack   = (w == waits);
        dmem.rdata = (w == waits) ? rdat : $urandom;
        @(negedge CLK);
      end
      dmem.ack   = 1'b0;
      dmem.rdata = $urandom;
      check("done_req", 32'(dmem.req), 32'd0);
      check("done_timeout", 32'(timeout), 32'd0);
      if (st) begin
        check("st_busy", 32'(busy), 32'd0);
        check("st_wb_en", 32'(wb_en), 32'd0);
      end else begin
        check("ld_busy", 32'(busy), 32'd1);
        check("ld_wb_en", 32'(wb_en), 32'(rd != 0));
        if (rd != 0) begin
          check("ld_wb_rd", 32'(wb_rd), 32'(rd));
          check("ld_wb_data", wb_data, ev);
        end
        @(negedge CLK);
        check("ld_idle", 32'(busy), 32'd0);
        check("ld_wb_end", 32'(wb_en), 32'd0);
      end
    end
  endtask

  initial begin
    bit          ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, n;

    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(dmem.req), 32'd0);
    check("rst_we", 32'(dmem.we), 32'd0);
    check("rst_addr", dmem.addr, 32'd0);
    check("rst_wdata", dmem.wdata, 32'd0);
    check("rst_be", 32'(dmem.be), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    RST_X = 1'b1;
    @(negedge CLK);

    // Three back-to-back ADDI-style instructions.
    valid = 1'b1; load = 1'b0; store = 1'b0; we_reg = 1'b1; rd_in = 5'd5; wd_reg = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("b2b_wb_en", 32'(wb_en), 32'd1);
      check("b2b_wb_rd", 32'(wb_rd), 32'(5 + i));
      check("b2b_wb_data", wb_data, 32'h1234 + 32'(i));
      check("b2b_busy", 32'(busy), 32'd0);
      if (i < 2) begin
        rd_in  = 5'(6 + i);
        wd_reg = 32'h1235 + 32'(i);
      end else begin
        valid = 1'b0;
      end
    end
    @(negedge CLK);
    check("b2b_end", 32'(wb_en), 32'd0);

    // Directed accesses from the test plan.
    do_op(0, 1, 3'd0, 32'h103, 32'hAB, 0, 0, 5'd0, 2, 32'h0);
    do_op(1, 0, 3'd0, 32'h102, 0, 0, 0, 5'd7, 0, 32'h0080_0000);
    do_op(1, 0, 3'd4, 32'h102, 0, 0, 0, 5'd7, 0, 32'h0080_0000);
    do_op(1, 0, 3'd1, 32'h102, 0, 0, 0, 5'd7, 0, 32'h8001_0000);
    do_op(1, 0, 3'd5, 32'h102, 0, 0, 0, 5'd8, 1, 32'h8001_0000);
    do_op(1, 0, 3'd2, 32'h101, 0, 0, 0, 5'd7, 0, 32'h0);
    do_op(0, 1, 3'd3, 32'h100, 32'h55, 0, 0, 5'd0, 0, 32'h0);
    do_op(1, 1, 3'd2, 32'h100, 32'h55, 0, 0, 5'd3, 0, 32'h0);
    do_op(1, 0, 3'd2, 32'h200, 0, 0, 0, 5'd0, 0, 32'hDEAD_BEEF);
    do_op(0, 1, 3'd1, 32'h302, 32'hCAFE, 0, 0, 5'd0, 0, 32'h0);
    do_op(0, 0, 3'd0, 32'h0, 0, 1, 32'h77, 5'd0, 0, 32'h0);
    // Ack in the last cycle the watchdog allows still completes the load.
    do_op(1, 0, 3'd2, 32'h40C, 0, 0, 0, 5'd12, int'(TOC) - 1, 32'h1357_9BDF);

    for (int k = 0; k < 80; k++) begin
      r  = int'($urandom_range(0, 9));
      ld = (r >= 3 && r < 6) || r == 9;
      st = (r >= 6);
      if (ld && !st && $urandom_range(0, 3) != 0) f3 = ld_codes[$urandom_range(0, 4)];
      else if (st && !ld && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      do_op(ld, st, f3, a, $urandom, 1'($urandom),
            $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            int'($urandom_range(0, TOC - 1)), $urandom);
    end

`ifdef MEM_TIMEOUT_EN
    // No ack: watchdog abandons the access.
    valid = 1'b1; load = 1'b1; store = 1'b0; funct3 = 3'd2; addr = 32'h300; rd_in = 5'd9;
    @(negedge CLK);
    scramble();
    n = 0;
    while (dmem.req === 1'b1 && n < 10) begin
      n++;
      check("to_pending", 32'(timeout), 32'd0);
      @(negedge CLK);
    end
    check("to_req_cycles", 32'(n), 32'(TOC));
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_wb_en", 32'(wb_en), 32'd0);
    @(negedge CLK);
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_wb_later", 32'(wb_en), 32'd0);
`else
    // Without the watchdog a long wait still completes normally.
    do_op(0, 1, 3'd2, 32'h500, 32'h2468_ACE0, 0, 0, 5'd0, 20, 32'h0);
    do_op(1, 0, 3'd0, 32'h503, 0, 0, 0, 5'd4, 12, 32'h7F00_0000);
`endif

    // Reset while a load waits: request drops at once, nothing written back.
    valid = 1'b1; load = 1'b1; store = 1'b0; funct3 = 3'd2; addr = 32'h600; rd_in = 5'd3;
    @(negedge CLK);
    scramble();
    check("rm_req_before", 32'(dmem.req), 32'd1);
    @(negedge CLK);
    #2;
    RST_X = 1'b0;
    dmem.ack = 1'b1;
    #1;
    check("rm_req", 32'(dmem.req), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_we", 32'(dmem.we), 32'd0);
    check("rm_addr", dmem.addr, 32'd0);
    check("rm_be", 32'(dmem.be), 32'd0);
    check("rm_wb_en", 32'(wb_en), 32'd0);
    check("rm_wb_data", wb_data, 32'd0);
    check("rm_timeout", 32'(timeout), 32'd0);
    @(negedge CLK);
    dmem.ack = 1'b0;
    RST_X = 1'b1;
    @(negedge CLK);
    check("rm_after_busy", 32'(busy), 32'd0);
    check("rm_after_wb", 32'(wb_en), 32'd0);
    check("rm_after_req", 32'(dmem.req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
